// File: rtl/sensor_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : sensor_monitor_if
// Description : Bundle of the signals between the sensor monitor, the raw
//               sensor bank and the system fault handler.
//                 enable, sensors[3:0], ack, clr_count  : into the monitor
//                 sample_strobe, error_now, alarm,
//                 err_count[CNT_W-1:0], busy           : out of the monitor
//               The master modport is the controlling side (handler/bench);
//               the slave modport is the monitor itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface sensor_monitor_if #(
  parameter int CNT_W = 4
);
  logic             enable;
  logic [3:0]       sensors;
  logic             ack;
  logic             clr_count;
  logic             sample_strobe;
  logic             error_now;
  logic             alarm;
  logic [CNT_W-1:0] err_count;
  logic             busy;

  modport master (
    output enable, sensors, ack, clr_count,
    input  sample_strobe, error_now, alarm, err_count, busy
  );

  modport slave (
    input  enable, sensors, ack, clr_count,
    output sample_strobe, error_now, alarm, err_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/sensor_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sensor_monitor
// Description : Periodic scan controller for the 4-bit sensor bank
//               {W,X,Y,Z} = sensors[3:0]. Samples every SAMPLE_PERIOD enabled
//               cycles, evaluates error = Z | (Y & (W | X)), raises a sticky
//               alarm after ERR_THRESH consecutive erroneous samples and keeps
//               a saturating count of erroneous samples.
// Ports       : clk   - system clock, rising edge
//               n_rst - asynchronous active-low reset
//               bus   - sensor_monitor_if.slave (enable, sensors, ack,
//                       clr_count in; sample_strobe, error_now, alarm,
//                       err_count, busy out). The interface CNT_W must
//                       match this module's CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_monitor #(
  parameter int SAMPLE_PERIOD = 4,
  parameter int ERR_THRESH    = 3,
  parameter int CNT_W         = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  sensor_monitor_if.slave bus
);

  localparam int PS_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int ST_W = $clog2(ERR_THRESH + 1);

  localparam logic [PS_W-1:0]  C_PS_LAST = PS_W'(SAMPLE_PERIOD - 1);
  localparam logic [ST_W-1:0]  C_ST_MAX  = ST_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [PS_W-1:0]  prescale_q,  prescale_d;
  logic [ST_W-1:0]  streak_q,    streak_d;
  logic             error_now_q, error_now_d;
  logic             alarm_q,     alarm_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             busy_q,      busy_d;

  logic             w_tick;
  logic             w_err;
  logic [ST_W-1:0]  w_streak_inc;

  assign w_tick = bus.enable && (prescale_q == C_PS_LAST);
  assign w_err  = bus.sensors[0] |
                  (bus.sensors[1] & (bus.sensors[3] | bus.sensors[2]));
  // Streak saturates at the threshold so it cannot wrap while in ALARM.
  assign w_streak_inc = (streak_q == C_ST_MAX) ? C_ST_MAX : streak_q + ST_W'(1);

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    error_now_d = error_now_q;
    err_count_d = err_count_q;

    // Prescaler is free-running while enabled, parked at 0 otherwise.
    prescale_d = (!bus.enable || w_tick) ? '0 : prescale_q + PS_W'(1);

    if (w_tick) begin
      error_now_d = w_err;
      streak_d    = w_err ? w_streak_inc : '0;
      if (w_err && (err_count_q != C_CNT_MAX)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end

    if (bus.clr_count) begin
      err_count_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        // A tick can already land in this cycle when SAMPLE_PERIOD is 1.
        if (bus.enable) begin
          state_d = (w_tick && (streak_d == C_ST_MAX)) ? ALARM : MONITOR;
        end
      end
      MONITOR: begin
        if (!bus.enable) begin
          state_d  = IDLE;
          streak_d = '0;
        end else if (w_tick && (streak_d == C_ST_MAX)) begin
          state_d = ALARM;
        end
      end
      ALARM: begin
        if (bus.ack) begin
          // Acknowledge restarts the streak, but a sample taken in the same
          // cycle still counts as its first member. With a threshold of 1
          // that single sample is enough to keep the alarm asserted.
          streak_d = (w_tick && w_err) ? ST_W'(1) : '0;
          if (streak_d == C_ST_MAX) begin
            state_d = ALARM;
          end else begin
            state_d = bus.enable ? MONITOR : IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        streak_d = '0;
      end
    endcase

    alarm_d = (state_d == ALARM);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      prescale_q  <= '0;
      streak_q    <= '0;
      error_now_q <= 1'b0;
      alarm_q     <= 1'b0;
      err_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescale_q  <= prescale_d;
      streak_q    <= streak_d;
      error_now_q <= error_now_d;
      alarm_q     <= alarm_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sample_strobe = w_tick;
  assign bus.error_now     = error_now_q;
  assign bus.alarm         = alarm_q;
  assign bus.err_count     = err_count_q;
  assign bus.busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_monitor
// Description : Directed self-checking bench for sensor_monitor with default
//               parameters (SAMPLE_PERIOD=4, ERR_THRESH=3, CNT_W=4).
//               Inputs change and outputs are sampled 1 time unit after the
//               rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_monitor;

  logic clk = 1'b0;
  logic n_rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sensor_monitor_if #(.CNT_W(4)) bus ();

  sensor_monitor #(
    .SAMPLE_PERIOD (4),
    .ERR_THRESH    (3),
    .CNT_W         (4)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, input logic [3:0] s);
    bus.enable  = 1'b1;
    bus.sensors = s;
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    n_rst         = 1'b0;
    bus.enable    = 1'b0;
    bus.sensors   = 4'b0000;
    bus.ack       = 1'b0;
    bus.clr_count = 1'b0;
    repeat (2) cyc();
    n_rst = 1'b1;
    cyc();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    run_cycles(20, 4'b0001);   // five erroneous ticks -> ALARM, count 5
    checks++; if (bus.alarm !== 1'b1) begin errors++;
      $display("FAIL rst_pre_alarm: got %0d expected 1", bus.alarm); end
    checks++; if (bus.err_count !== 4'd5) begin errors++;
      $display("FAIL rst_pre_count: got %0d expected 5", bus.err_count); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (bus.alarm !== 1'b0) begin errors++;
      $display("FAIL rst_alarm: got %0d expected 0", bus.alarm); end
    checks++; if (bus.error_now !== 1'b0) begin errors++;
      $display("FAIL rst_error_now: got %0d expected 0", bus.error_now); end
    checks++; if (bus.err_count !== 4'd0) begin errors++;
      $display("FAIL rst_count: got %0d expected 0", bus.err_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy: got %0d expected 0", bus.busy); end
    checks++; if (bus.sample_strobe !== 1'b0) begin errors++;
      $display("FAIL rst_strobe: got %0d expected 0", bus.sample_strobe); end
    bus.enable = 1'b0;
    cyc();
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.sample_strobe !== 1'b0) begin errors++;
        $display("FAIL rst_idle_strobe[%0d]: got %0d expected 0", i, bus.sample_strobe); end
      cyc();
    end
    checks++; if ({bus.alarm, bus.busy, bus.error_now} !== 3'b000) begin errors++;
      $display("FAIL rst_idle_flags: got %b expected 000", {bus.alarm, bus.busy, bus.error_now}); end
    checks++; if (bus.err_count !== 4'd0) begin errors++;
      $display("FAIL rst_idle_count: got %0d expected 0", bus.err_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_alarm_raise();
    logic exp_strobe;
    do_reset();
    bus.enable  = 1'b1;
    bus.sensors = 4'b0001;
    for (int i = 1; i <= 12; i++) begin
      exp_strobe = (i % 4 == 0);
      checks++; if (bus.sample_strobe !== exp_strobe) begin errors++;
        $display("FAIL raise_strobe[cycle %0d]: got %0d expected %0d", i, bus.sample_strobe, exp_strobe); end
      if (i == 5) begin
        checks++; if (bus.error_now !== 1'b1) begin errors++;
          $display("FAIL raise_error_now_first: got %0d expected 1", bus.error_now); end
      end
      if (i == 12) begin
        checks++; if (bus.alarm !== 1'b0) begin errors++;
          $display("FAIL raise_alarm_early: got %0d expected 0", bus.alarm); end
      end
      cyc();
    end
    checks++; if (bus.alarm !== 1'b1) begin errors++;
      $display("FAIL raise_alarm: got %0d expected 1", bus.alarm); end
    checks++; if (bus.err_count !== 4'd3) begin errors++;
      $display("FAIL raise_count: got %0d expected 3", bus.err_count); end
    checks++; if (bus.busy !== 1'b1) begin errors++;
      $display("FAIL raise_busy: got %0d expected 1", bus.busy); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_error_function();
    logic [3:0] pats [5];
    logic       exps [5];
    logic [3:0] seq  [5];
    pats = '{4'b0110, 4'b1010, 4'b0010, 4'b1100, 4'b0000};
    exps = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    seq  = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_cycles(4, pats[k]);
      checks++; if (bus.error_now !== exps[k]) begin errors++;
        $display("FAIL errfn_%b: got %0d expected %0d", pats[k], bus.error_now, exps[k]); end
      checks++; if (bus.alarm !== 1'b0) begin errors++;
        $display("FAIL errfn_alarm_%b: got %0d expected 0", pats[k], bus.alarm); end
    end
    checks++; if (bus.err_count !== 4'd2) begin errors++;
      $display("FAIL errfn_count: got %0d expected 2", bus.err_count); end

    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_cycles(4, seq[k]);
      checks++; if (bus.alarm !== 1'b0) begin errors++;
        $display("FAIL streak_alarm[%0d]: got %0d expected 0", k, bus.alarm); end
    end
    checks++; if (bus.err_count !== 4'd4) begin errors++;
      $display("FAIL streak_count: got %0d expected 4", bus.err_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_ack();
    do_reset();
    run_cycles(12, 4'b0001);
    checks++; if (bus.alarm !== 1'b1) begin errors++;
      $display("FAIL ack_pre_alarm: got %0d expected 1", bus.alarm); end
    // plain ack on a non-tick cycle
    bus.sensors = 4'b0000;
    bus.ack     = 1'b1;
    cyc();
    bus.ack = 1'b0;
    checks++; if (bus.alarm !== 1'b0) begin errors++;
      $display("FAIL ack_clear: got %0d expected 0", bus.alarm); end
    checks++; if (bus.busy !== 1'b1) begin errors++;
      $display("FAIL ack_busy: got %0d expected 1", bus.busy); end
    // ack while not in ALARM has no effect
    bus.ack = 1'b1;
    run_cycles(8, 4'b0110);
    bus.ack = 1'b0;
    checks++; if (bus.alarm !== 1'b0) begin errors++;
      $display("FAIL ack_rearm_early: got %0d expected 0", bus.alarm); end
    run_cycles(4, 4'b0110);
    checks++; if (bus.alarm !== 1'b1) begin errors++;
      $display("FAIL ack_rearm: got %0d expected 1", bus.alarm); end
    // bring prescaler to its last count, then ack on the tick cycle
    run_cycles(2, 4'b0001);
    checks++; if (bus.sample_strobe !== 1'b1) begin errors++;
      $display("FAIL ack_tick_strobe: got %0d expected 1", bus.sample_strobe); end
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    checks++; if (bus.alarm !== 1'b0) begin errors++;
      $display("FAIL ack_tick_clear: got %0d expected 0", bus.alarm); end
    checks++; if (bus.error_now !== 1'b1) begin errors++;
      $display("FAIL ack_tick_error_now: got %0d expected 1", bus.error_now); end
    run_cycles(4, 4'b0001);   // streak 1 -> 2
    checks++; if (bus.alarm !== 1'b0) begin errors++;
      $display("FAIL ack_tick_streak2: got %0d expected 0", bus.alarm); end
    run_cycles(4, 4'b0001);   // streak 2 -> 3
    checks++; if (bus.alarm !== 1'b1) begin errors++;
      $display("FAIL ack_tick_streak3: got %0d expected 1", bus.alarm); end
    checks++; if (bus.err_count !== 4'd9) begin errors++;
      $display("FAIL ack_count: got %0d expected 9", bus.err_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_counter();
    do_reset();
    run_cycles(60, 4'b0001);  // 15 erroneous ticks
    checks++; if (bus.err_count !== 4'd15) begin errors++;
      $display("FAIL cnt_15: got %0d expected 15", bus.err_count); end
    run_cycles(20, 4'b0001);  // 5 more, saturated
    checks++; if (bus.err_count !== 4'd15) begin errors++;
      $display("FAIL cnt_sat: got %0d expected 15", bus.err_count); end
    run_cycles(3, 4'b0001);
    checks++; if (bus.sample_strobe !== 1'b1) begin errors++;
      $display("FAIL cnt_clr_strobe: got %0d expected 1", bus.sample_strobe); end
    bus.clr_count = 1'b1;
    cyc();
    bus.clr_count = 1'b0;
    checks++; if (bus.err_count !== 4'd0) begin errors++;
      $display("FAIL cnt_clr: got %0d expected 0", bus.err_count); end
    run_cycles(4, 4'b0001);
    checks++; if (bus.err_count !== 4'd1) begin errors++;
      $display("FAIL cnt_after_clr: got %0d expected 1", bus.err_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_enable_drop();
    logic exp_strobe;
    do_reset();
    run_cycles(8, 4'b0001);   // streak 2, count 2
    run_cycles(2, 4'b0001);   // prescale now 2
    bus.enable = 1'b0;
    checks++; if (bus.sample_strobe !== 1'b0) begin errors++;
      $display("FAIL drop_strobe: got %0d expected 0", bus.sample_strobe); end
    cyc();
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL drop_busy: got %0d expected 0", bus.busy); end
    checks++; if (bus.err_count !== 4'd2 || bus.error_now !== 1'b1) begin errors++;
      $display("FAIL drop_hold: got count=%0d err=%0d expected count=2 err=1", bus.err_count, bus.error_now); end
    repeat (3) cyc();
    bus.enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_strobe = (i == 4);
      checks++; if (bus.sample_strobe !== exp_strobe) begin errors++;
        $display("FAIL reen_strobe[cycle %0d]: got %0d expected %0d", i, bus.sample_strobe, exp_strobe); end
      cyc();
    end
    checks++; if (bus.alarm !== 1'b0) begin errors++;
      $display("FAIL reen_streak_cleared: got %0d expected 0", bus.alarm); end
    checks++; if (bus.err_count !== 4'd3) begin errors++;
      $display("FAIL reen_count: got %0d expected 3", bus.err_count); end
    run_cycles(8, 4'b0001);
    checks++; if (bus.alarm !== 1'b1) begin errors++;
      $display("FAIL reen_alarm: got %0d expected 1", bus.alarm); end
    bus.enable = 1'b0;
    repeat (4) cyc();
    checks++; if (bus.alarm !== 1'b1 || bus.busy !== 1'b1) begin errors++;
      $display("FAIL drop_alarm_hold: got alarm=%0d busy=%0d expected 1 1", bus.alarm, bus.busy); end
    checks++; if (bus.sample_strobe !== 1'b0) begin errors++;
      $display("FAIL drop_alarm_strobe: got %0d expected 0", bus.sample_strobe); end
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    checks++; if (bus.alarm !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL drop_alarm_ack: got alarm=%0d busy=%0d expected 0 0", bus.alarm, bus.busy); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    n_rst         = 1'b0;
    bus.enable    = 1'b0;
    bus.sensors   = 4'b0000;
    bus.ack       = 1'b0;
    bus.clr_count = 1'b0;
    test_reset();
    test_alarm_raise();
    test_error_function();
    test_ack();
    test_counter();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
